spawn_scheduler: RTL and testbench

//   Shares the free-running 4-bit random source (LFSR output o[3:0]) between N

---
 rtl/spawn_scheduler.sv | 112 +++++++++++
 tb/tb_spawn_scheduler.sv | 120 ++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
// Round-robin arbiter that hands the shared random source to N spawners,
// then enforces a random cooldown (MIN_GAP + rnd game ticks) before the next grant.
module spawn_scheduler #(
    parameter  int N_REQ   = 4,
    parameter  int RND_W   = 4,
    parameter  int MIN_GAP = 2,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic [RND_W-1:0] rnd,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic [RND_W-1:0] gnt_val,
    output logic             busy
);
    localparam int CNT_W = RND_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        COOL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [RND_W-1:0]   gnt_val_q, gnt_val_d;
    logic [CNT_W-1:0]   cool_cnt_q, cool_cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [CNT_W-1:0]   load_val;
    int                 idx;

    assign load_val = CNT_W'(MIN_GAP) + {1'b0, rnd};

    // First requester at or after rr_ptr, wrapping from N_REQ-1 back to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        gnt_id_d   = gnt_id_q;
        gnt_val_d  = gnt_val_q;
        cool_cnt_d = cool_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    gnt_d[win] = 1'b1;
                    gnt_id_d   = win;
                    gnt_val_d  = rnd;
                    rr_ptr_d   = (int'(win) == N_REQ - 1) ? '0 : ID_W'(int'(win) + 1);
                    cool_cnt_d = load_val;
                    // A zero cooldown lets the next grant land on the very next edge.
                    state_d    = (load_val == '0) ? IDLE : COOL;
                end
            end
            COOL: begin
                if (tick) begin
                    cool_cnt_d = cool_cnt_q - 1'b1;
                    if (cool_cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            gnt_val_q  <= '0;
            cool_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_val_q  <= gnt_val_d;
            cool_cnt_q <= cool_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_val = gnt_val_q;
    assign busy    = (state_q == COOL);

endmodule

// File: tb/tb_spawn_scheduler.sv
// Drives two schedulers (MIN_GAP=2 and MIN_GAP=0) with shared stimulus and
// compares every cycle against an integer-level behavioural model.
module tb_spawn_scheduler;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, tick, enable;
    logic [W-1:0] rnd;
    logic [N-1:0] req;

    logic [N-1:0] gnt0, gnt1;
    logic [1:0]   id0, id1;
    logic [W-1:0] val0, val1;
    logic         busy0, busy1;

    spawn_scheduler #(.N_REQ(N), .RND_W(W), .MIN_GAP(2)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable), .rnd(rnd), .req(req),
        .gnt(gnt0), .gnt_id(id0), .gnt_val(val0), .busy(busy0)
    );

    spawn_scheduler #(.N_REQ(N), .RND_W(W), .MIN_GAP(0)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable), .rnd(rnd), .req(req),
        .gnt(gnt1), .gnt_id(id1), .gnt_val(val1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model state per instance: remaining cooldown ticks (0 = idle), pointer, last grant.
    int gap[2]    = '{2, 0};
    int m_left[2] = '{0, 0};
    int m_ptr[2]  = '{0, 0};
    int m_gnt[2]  = '{0, 0};
    int m_id[2]   = '{0, 0};
    int m_val[2]  = '{0, 0};

    task automatic model_step();
        int w;
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                m_left[j] = 0; m_ptr[j] = 0; m_gnt[j] = 0; m_id[j] = 0; m_val[j] = 0;
            end else begin
                m_gnt[j] = 0;
                if (m_left[j] == 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && req[(m_ptr[j] + k) % N]) w = (m_ptr[j] + k) % N;
                    end
                    if (enable && w >= 0) begin
                        m_gnt[j]  = 1 << w;
                        m_id[j]   = w;
                        m_val[j]  = int'(rnd);
                        m_ptr[j]  = (w + 1) % N;
                        m_left[j] = gap[j] + int'(rnd);
                        if (j == 0)
                            $display("txn t=%0t gap2 grant id=%0d val=%0d cooldown=%0d",
                                     $time, w, m_val[j], m_left[j]);
                    end
                end else if (tick) begin
                    m_left[j] = m_left[j] - 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit t, input bit e, input int rv, input int rq);
        @(negedge clk);
        rst = r; tick = t; enable = e; rnd = W'(rv); req = N'(rq);
        model_step();
        @(posedge clk);
        #1;
        check("gnt_g2",     32'(gnt0),  32'(m_gnt[0]));
        check("gnt_id_g2",  32'(id0),   32'(m_id[0]));
        check("gnt_val_g2", 32'(val0),  32'(m_val[0]));
        check("busy_g2",    32'(busy0), 32'(m_left[0] != 0));
        check("gnt_g0",     32'(gnt1),  32'(m_gnt[1]));
        check("gnt_id_g0",  32'(id1),   32'(m_id[1]));
        check("gnt_val_g0", 32'(val1),  32'(m_val[1]));
        check("busy_g0",    32'(busy1), 32'(m_left[1] != 0));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; enable = 1'b1; rnd = '0; req = '1;
        // Reset with everything requesting and ticking.
        repeat (2) cycle(1, 1, 1, 0, 4'b1111);
        // All request, rnd=0, tick every cycle: rotating grants.
        repeat (16) cycle(0, 1, 1, 0, 4'b1111);
        // rnd=5, tick every 4th cycle: long cooldown.
        cycle(1, 0, 1, 5, 4'b0000);
        for (int i = 0; i < 40; i++) cycle(0, (i % 4) == 3, 1, 5, 4'b0001);
        // Grants held off by enable, then released.
        cycle(1, 0, 0, 3, 4'b0000);
        repeat (10) cycle(0, 1, 0, 3, 4'b0100);
        repeat (3) cycle(0, 0, 1, 3, 4'b0100);
        // Reset in the middle of a cooldown.
        cycle(0, 0, 1, 2, 4'b1010);
        cycle(0, 1, 1, 2, 4'b1010);
        cycle(1, 0, 1, 2, 4'b1010);
        repeat (4) cycle(0, 1, 1, 2, 4'b1010);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 100) == 0, ($urandom % 3) == 0, ($urandom % 8) != 0,
                  int'($urandom % 16), ($urandom % 4 == 0) ? 0 : int'($urandom % 16));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
